// File: rtl/div_pkg.sv
// Shared definitions for the div_8 restoring divider: data width,
// iteration counter width and the FSM state encoding.
package div_pkg;

  localparam int DIV_WIDTH = 8;
  localparam int CNT_W     = 3;

  localparam logic [CNT_W-1:0] LAST_ITER = 3'd7;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

endpackage

// File: rtl/div_8_trial_sub.sv
// trial_sub: combinational ripple-borrow subtractor used for the trial
// subtraction of each divider iteration (diff = a - b, borrow_out = a < b).
module trial_sub
  import div_pkg::*;
#(
  parameter int W = DIV_WIDTH + 1
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic [W-1:0] diff,
  output logic         borrow_out
);

  logic [W:0] w_borrow;

  // Bit-serial borrow chain from LSB to MSB.
  always_comb begin
    w_borrow    = '0;
    diff        = '0;
    for (int i = 0; i < W; i++) begin
      diff[i]       = a[i] ^ b[i] ^ w_borrow[i];
      w_borrow[i+1] = (~a[i] & b[i]) | (~(a[i] ^ b[i]) & w_borrow[i]);
    end
    borrow_out = w_borrow[W];
  end

endmodule

// File: rtl/div_8.sv
// div_8: 8-bit unsigned restoring divider with valid/ready handshakes.
// Optional feature macro: DIV8_EARLY_EXIT_EN (divisor > dividend finishes
// on the accepting edge with quotient 0, remainder = dividend).
//
// Handshake: a transfer happens on a rising edge where valid && ready are
// both high. in_ready is high only in IDLE; out_valid is high only in DONE.
// The pair {in_ready, out_valid} fully exposes the FSM state:
// IDLE = 2'b10, RUN = 2'b00, DONE = 2'b01.
module div_8
  import div_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  state_t           r_state;
  state_t           w_next_state;

  logic [WIDTH:0]   r_rem;      // partial remainder R (9 bits)
  logic [WIDTH-1:0] r_q;        // working quotient / shifted dividend
  logic [WIDTH-1:0] r_div;      // captured divisor
  logic [CNT_W-1:0] r_cnt;
  logic [WIDTH-1:0] r_quot;
  logic [WIDTH-1:0] r_remo;
  logic             r_dbz;

  logic [WIDTH:0]   w_shift;
  logic [WIDTH:0]   w_sub_b;
  logic [WIDTH:0]   w_diff;
  logic             w_borrow;
  logic [WIDTH:0]   w_r_next;
  logic [WIDTH-1:0] w_q_next;
  logic             w_early;
  logic             w_unused_msb;

  // Shift {R,Q} left by one: R takes Q's MSB as its new LSB.
  assign w_shift  = {r_rem[WIDTH-1:0], r_q[WIDTH-1]};
  assign w_sub_b  = {1'b0, r_div};

  trial_sub #(.W(WIDTH + 1)) u_trial (
    .a          (w_shift),
    .b          (w_sub_b),
    .diff       (w_diff),
    .borrow_out (w_borrow)
  );

  // Restore on borrow, otherwise keep the difference and set the quotient bit.
  assign w_r_next = w_borrow ? w_shift : w_diff;
  assign w_q_next = {r_q[WIDTH-2:0], ~w_borrow};

  // R stays below the divisor, so its top bit only matters inside the shift.
  assign w_unused_msb = r_rem[WIDTH];

`ifdef DIV8_EARLY_EXIT_EN
  assign w_early = (divisor > dividend);
`else
  assign w_early = 1'b0;
`endif

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next_state;
  end

  // Next-state logic.
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE: if (in_valid) begin
        if (divisor == '0 || w_early) w_next_state = S_DONE;
        else                          w_next_state = S_RUN;
      end
      S_RUN:  if (r_cnt == LAST_ITER) w_next_state = S_DONE;
      S_DONE: if (out_ready)          w_next_state = S_IDLE;
      default:                        w_next_state = S_IDLE;
    endcase
  end

  // Handshake outputs decoded from state.
  always_comb begin
    in_ready  = (r_state == S_IDLE);
    out_valid = (r_state == S_DONE);
  end

  // Datapath: operand capture, iterations and result registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rem  <= '0;
      r_q    <= '0;
      r_div  <= '0;
      r_cnt  <= '0;
      r_quot <= '0;
      r_remo <= '0;
      r_dbz  <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: if (in_valid) begin
          r_div <= divisor;
          if (divisor == '0) begin
            r_quot <= '1;
            r_remo <= dividend;
            r_dbz  <= 1'b1;
          end else if (w_early) begin
            r_quot <= '0;
            r_remo <= dividend;
            r_dbz  <= 1'b0;
          end else begin
            r_rem  <= '0;
            r_q    <= dividend;
            r_cnt  <= '0;
            r_dbz  <= 1'b0;
          end
        end
        S_RUN: begin
          r_rem <= w_r_next;
          r_q   <= w_q_next;
          r_cnt <= r_cnt + 1'b1;
          if (r_cnt == LAST_ITER) begin
            r_quot <= w_q_next;
            r_remo <= w_r_next[WIDTH-1:0];
          end
        end
        default: ;
      endcase
    end
  end

  assign quotient    = r_quot;
  assign remainder   = r_remo;
  assign div_by_zero = r_dbz;

endmodule

// File: tb/tb_div_8.sv
// Testbench for div_8: directed corner cases, a backpressure hold, a reset
// abort mid-division and randomized operands checked against an arithmetic
// reference model. Latency is counted in edges after the accepting edge
// (0 = result already valid right after the accepting edge).
module tb_div_8;

`ifdef DIV8_EARLY_EXIT_EN
  localparam bit EARLY = 1'b1;
`else
  localparam bit EARLY = 1'b0;
`endif

  logic       clk;
  logic       rst_n;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] dividend;
  logic [7:0] divisor;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] quotient;
  logic [7:0] remainder;
  logic       div_by_zero;

  int n_checks = 0;
  int n_fail   = 0;

  // Expected {quotient, remainder, div_by_zero}
  logic [16:0] exp_q[$];

  div_8 #(.WIDTH(8)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .dividend    (dividend),
    .divisor     (divisor),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .quotient    (quotient),
    .remainder   (remainder),
    .div_by_zero (div_by_zero)
  );

  // Clock / watchdog
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Reference model: plain arithmetic plus the divide-by-zero and
  // early-exit rules. Returns expected result and latency.
  task automatic model(input logic [7:0] a, input logic [7:0] b,
                       output logic [16:0] res, output int lat);
    if (b == 8'd0) begin
      res = {8'hFF, a, 1'b1};
      lat = 0;
    end else if (EARLY && (b > a)) begin
      res = {8'h00, a, 1'b0};
      lat = 0;
    end else begin
      res = {a / b, a % b, 1'b0};
      lat = 8;
    end
  endtask

  // Driver: one full transaction with 'hold' cycles of out_ready low in DONE.
  task automatic do_div(input logic [7:0] a, input logic [7:0] b, input int hold);
    logic [16:0] res;
    logic [16:0] exp;
    int          lat;
    int          n;
    model(a, b, res, lat);
    exp_q.push_back(res);
    n = 0;
    while (!in_ready && n < 20) begin
      @(posedge clk); #1; n++;
    end
    check("in_ready_before_accept", 32'(in_ready), 32'd1);
    in_valid = 1'b1;
    dividend = a;
    divisor  = b;
    @(posedge clk); #1;
    in_valid = 1'b0;
    dividend = 8'($urandom);
    divisor  = 8'($urandom);
    n = 0;
    while (!out_valid && n < 20) begin
      check("in_ready_busy", 32'(in_ready), 32'd0);
      @(posedge clk); #1; n++;
    end
    check("latency", 32'(n), 32'(lat));
    exp = exp_q.pop_front();
    check("quotient", 32'(quotient), 32'(exp[16:9]));
    check("remainder", 32'(remainder), 32'(exp[8:1]));
    check("div_by_zero", 32'(div_by_zero), 32'(exp[0]));
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      check("hold_out_valid", 32'(out_valid), 32'd1);
      check("hold_in_ready", 32'(in_ready), 32'd0);
      check("hold_quotient", 32'(quotient), 32'(exp[16:9]));
      check("hold_remainder", 32'(remainder), 32'(exp[8:1]));
      check("hold_dbz", 32'(div_by_zero), 32'(exp[0]));
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check("consumed_out_valid", 32'(out_valid), 32'd0);
    check("consumed_in_ready", 32'(in_ready), 32'd1);
  endtask

  // Main sequence
  initial begin
    logic [7:0] a;
    logic [7:0] b;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    dividend  = 8'd0;
    divisor   = 8'd0;
    #2;
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_quotient", 32'(quotient), 32'd0);
    check("rst_remainder", 32'(remainder), 32'd0);
    check("rst_dbz", 32'(div_by_zero), 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;

    do_div(8'd100, 8'd7,   0);
    do_div(8'd255, 8'd1,   1);
    do_div(8'd255, 8'd255, 0);
    do_div(8'd5,   8'd0,   2);
    do_div(8'd3,   8'd10,  0);
    do_div(8'd0,   8'd3,   0);
    do_div(8'd100, 8'd7,   5);

    for (int t = 0; t < 40; t++) begin
      a = 8'($urandom_range(0, 255));
      if ($urandom_range(0, 7) == 0)      b = 8'd0;
      else if ($urandom_range(0, 3) == 0) b = 8'($urandom_range(1, 15));
      else                                b = 8'($urandom_range(1, 255));
      do_div(a, b, int'($urandom_range(0, 3)));
    end

    // Reset abort in the middle of a division
    in_valid = 1'b1;
    dividend = 8'd100;
    divisor  = 8'd7;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (4) @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    check("abort_in_ready", 32'(in_ready), 32'd1);
    check("abort_out_valid", 32'(out_valid), 32'd0);
    check("abort_quotient", 32'(quotient), 32'd0);
    check("abort_remainder", 32'(remainder), 32'd0);
    check("abort_dbz", 32'(div_by_zero), 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 12; i++) begin
      @(posedge clk); #1;
      check("abort_no_result", 32'(out_valid), 32'd0);
    end
    do_div(8'd200, 8'd9, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
